// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM encoding, latch
// layout and counter widths.
package mem_arbiter_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int WD_W    = 8;
  localparam int DRAIN_W = 3;

  typedef enum logic [1:0] {
    ST_DRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2,
    ST_TURN  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } req_latch_t;

  // Drain length covers the longest ready pulse a RAM could still owe us.
  function automatic logic [DRAIN_W-1:0] drain_load(input int wait_states);
    return DRAIN_W'(wait_states + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// pointer owner. The pointer itself is owned by the caller.
module arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       gnt_o
);

  always_comb begin
    gnt_o = 1'b0;
    case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ptr_i;
      default: gnt_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter placing two req/ready masters in front of one
// wait-state RAM, with a turnaround cycle, an access watchdog and a drain window.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_err,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_readdata,
  output arb_state_e        dbg_state_o
);

  // Handshake: a master holds read/write (with addr/data) until it sees its
  // own one-cycle ready or err pulse; the RAM answers a held s_read/s_write
  // with a one-cycle s_ready, and s_readdata is only meaningful alongside it.

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = drain_load(WAIT_STATES);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              gnt_q, gnt_d;
  req_latch_t        lat_q, lat_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  logic [1:0]        req_vec;
  logic              pick;
  logic              in_busy;
  logic              done;
  logic              abort;
  logic              fwd_ready;
  logic              fwd_err;
  req_latch_t        req0, req1;

  assign req_vec = {m1_read | m1_write, m0_read | m0_write};

  always_comb begin
    req0 = '{addr: m0_addr, read: m0_read, write: m0_write, wdata: m0_writedata};
    req1 = '{addr: m1_addr, read: m1_read, write: m1_write, wdata: m1_writedata};
  end

  arb_rr2 u_rr (
    .req_i (req_vec),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  assign in_busy = (state_q == ST_BUSY);
  assign done    = in_busy && s_ready;
  // A ready arriving in the last allowed cycle still wins over the abort.
  assign abort   = in_busy && !s_ready && (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_DRAIN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DRAIN: if (drain_q <= DRAIN_W'(1)) state_d = ST_IDLE;
      ST_IDLE:  if (|req_vec) state_d = ST_BUSY;
      ST_BUSY: begin
        if (done) begin
          state_d = ST_TURN;
        end else if (abort) begin
          state_d = ST_DRAIN;
        end
      end
      ST_TURN:  state_d = ST_IDLE;
      default:  state_d = ST_DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      lat_q   <= '0;
      wd_q    <= '0;
      drain_q <= DRAIN_LOAD;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      lat_q   <= lat_d;
      wd_q    <= wd_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    lat_d   = lat_q;
    wd_d    = wd_q;
    drain_d = drain_q;
    case (state_q)
      ST_DRAIN: begin
        if (drain_q != '0) drain_d = drain_q - 1'b1;
      end
      ST_IDLE: begin
        if (|req_vec) begin
          gnt_d = pick;
          lat_d = pick ? req1 : req0;
          wd_d  = '0;
        end
      end
      ST_BUSY: begin
        wd_d = wd_q + 1'b1;
        if (done) begin
          ptr_d = ~gnt_q;
        end else if (abort) begin
          ptr_d   = ~gnt_q;
          drain_d = DRAIN_LOAD;
        end
      end
      default: ;
    endcase
  end

  // Pulses are suppressed while reset is asserted so a reset landing on the
  // completing cycle never leaks a ready or err to either master.
  assign fwd_ready = done && !reset;
  assign fwd_err   = abort && !reset;

  always_comb begin
    s_addr      = '0;
    s_read      = 1'b0;
    s_write     = 1'b0;
    s_writedata = '0;
    if (in_busy) begin
      s_addr      = lat_q.addr;
      s_read      = lat_q.read;
      s_write     = lat_q.write;
      s_writedata = lat_q.wdata;
    end
    m0_ready    = fwd_ready && !gnt_q;
    m1_ready    = fwd_ready && gnt_q;
    m0_readdata = (fwd_ready && !gnt_q) ? s_readdata : '0;
    m1_readdata = (fwd_ready && gnt_q) ? s_readdata : '0;
    m0_err      = fwd_err && !gnt_q;
    m1_err      = fwd_err && gnt_q;
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural wait-state RAM, two master drivers and a
// per-master readdata scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int WS = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] m0_addr, m1_addr, m0_writedata, m1_writedata;
  logic       m0_read, m0_write, m1_read, m1_write;
  logic       m0_ready, m1_ready, m0_err, m1_err;
  logic [7:0] m0_readdata, m1_readdata;
  logic [7:0] s_addr, s_writedata, s_readdata;
  logic       s_read, s_write, s_ready;
  arb_state_e dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  int         order_q[$];
  logic       err_ok0 = 1'b0;
  logic       err_ok1 = 1'b0;

  mem_arbiter #(.WAIT_STATES(WS), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_ready(m0_ready), .m0_readdata(m0_readdata),
    .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_ready(m1_ready), .m1_readdata(m1_readdata),
    .m1_err(m1_err),
    .s_addr(s_addr), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_ready(s_ready), .s_readdata(s_readdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  // An access is captured on its first cycle and completes WS cycles later
  // even if the request disappears, which produces stale ready pulses.
  logic [7:0] ram [256];
  logic       ram_pend = 1'b0;
  int         ram_cnt = 0;
  logic [7:0] ram_a = 8'h00;
  logic       ram_w = 1'b0;
  logic [7:0] ram_wd = 8'h00;
  logic       ram_stall = 1'b0;

  assign s_ready = (WS == 0) ? (!ram_stall && (s_read || s_write))
                             : (ram_pend && ram_cnt == WS);
  assign s_readdata = !s_ready ? 8'h00 :
                      (WS == 0) ? (s_write ? 8'h00 : ram[s_addr]) :
                      (ram_w ? 8'h00 : ram[ram_a]);

  always @(posedge clk) begin
    if (WS == 0) begin
      if (s_ready && s_write) ram[s_addr] <= s_writedata;
    end else if (ram_pend) begin
      if (ram_cnt == WS) begin
        ram_pend <= 1'b0;
        if (ram_w) ram[ram_a] <= ram_wd;
      end else begin
        ram_cnt <= ram_cnt + 1;
      end
    end else if ((s_read || s_write) && !ram_stall) begin
      ram_pend <= 1'b1;
      ram_cnt  <= 1;
      ram_a    <= s_addr;
      ram_w    <= s_write;
      ram_wd   <= s_writedata;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (m0_ready === 1'b1) begin
      checks++;
      if (m1_ready === 1'b1) begin
        failures++;
        $display("FAIL both_ready m0_ready=%b m1_ready=%b required one-hot", m0_ready, m1_ready);
      end else if (exp0_q.size() == 0) begin
        failures++;
        $display("FAIL m0_unexpected_ready cycle=%0d readdata=%h", cyc, m0_readdata);
      end else begin
        e = exp0_q.pop_front();
        if (m0_readdata !== e) begin
          failures++;
          $display("FAIL m0_readdata cycle=%0d got=%h exp=%h", cyc, m0_readdata, e);
        end
      end
      order_q.push_back(0);
    end else begin
      checks++;
      if (m0_readdata !== 8'h00) begin
        failures++;
        $display("FAIL m0_readdata_idle cycle=%0d got=%h exp=00", cyc, m0_readdata);
      end
    end
    if (m1_ready === 1'b1) begin
      checks++;
      if (exp1_q.size() == 0) begin
        failures++;
        $display("FAIL m1_unexpected_ready cycle=%0d readdata=%h", cyc, m1_readdata);
      end else begin
        e = exp1_q.pop_front();
        if (m1_readdata !== e) begin
          failures++;
          $display("FAIL m1_readdata cycle=%0d got=%h exp=%h", cyc, m1_readdata, e);
        end
      end
      order_q.push_back(1);
    end else begin
      checks++;
      if (m1_readdata !== 8'h00) begin
        failures++;
        $display("FAIL m1_readdata_idle cycle=%0d got=%h exp=00", cyc, m1_readdata);
      end
    end
    if (!err_ok0) begin
      checks++;
      if (m0_err !== 1'b0) begin
        failures++;
        $display("FAIL m0_unexpected_err cycle=%0d got=%b exp=0", cyc, m0_err);
      end
    end
    if (!err_ok1) begin
      checks++;
      if (m1_err !== 1'b0) begin
        failures++;
        $display("FAIL m1_unexpected_err cycle=%0d got=%b exp=0", cyc, m1_err);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic m_access(input int m, input logic [7:0] a, input logic rd, input logic wr,
                          input logic [7:0] wd, input logic [7:0] exp_rd, input logic expect_err,
                          output int issue_cyc, output int done_cyc, output logic got_err);
    bit fin;
    @(posedge clk); #1;
    if (m == 0) begin
      m0_addr = a; m0_read = rd; m0_write = wr; m0_writedata = wd;
      if (!expect_err) exp0_q.push_back(exp_rd);
    end else begin
      m1_addr = a; m1_read = rd; m1_write = wr; m1_writedata = wd;
      if (!expect_err) exp1_q.push_back(exp_rd);
    end
    issue_cyc = cyc;
    done_cyc  = -1;
    got_err   = 1'b0;
    fin       = 1'b0;
    for (int n = 0; n < 200 && !fin; n++) begin
      @(negedge clk);
      if (m == 0 && (m0_ready === 1'b1 || m0_err === 1'b1)) begin
        fin = 1'b1; done_cyc = cyc; got_err = m0_err;
      end else if (m == 1 && (m1_ready === 1'b1 || m1_err === 1'b1)) begin
        fin = 1'b1; done_cyc = cyc; got_err = m1_err;
      end
    end
    @(posedge clk); #1;
    if (m == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
    else begin m1_read = 1'b0; m1_write = 1'b0; end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (WS + 1) @(posedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({m0_ready, m0_readdata, m0_err, m1_ready, m1_readdata, m1_err,
           s_addr, s_read, s_write, s_writedata} !== '0 || dbg_state !== ST_DRAIN) begin
        failures++;
        $display("FAIL reset_outputs state=%0d s_read=%b s_addr=%h exp all zero in DRAIN",
                 dbg_state, s_read, s_addr);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k <= WS; k++) begin
      @(negedge clk);
      checks++;
      if (dbg_state !== ST_DRAIN) begin
        failures++;
        $display("FAIL drain_after_reset k=%0d got=%0d exp=%0d", k, dbg_state, ST_DRAIN);
      end
    end
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL idle_after_drain got=%0d exp=%0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_single_read();
    int ic, dc;
    logic ge, e;
    fork
      m_access(0, 8'h34, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, ic, dc, ge);
      begin
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          e = (k >= 1 && k <= 1 + WS);
          checks++;
          if (s_read !== e || (e && s_addr !== 8'h34)) begin
            failures++;
            $display("FAIL single_read_s_read k=%0d got=%b/%h exp=%b/34", k, s_read, s_addr, e);
          end
        end
      end
    join
    checks++;
    if (dc !== ic + 1 + WS || ge !== 1'b0) begin
      failures++;
      $display("FAIL single_read_latency got=%0d exp=%0d err=%b", dc - ic, 1 + WS, ge);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    order_q.delete();
    fork
      for (int i = 0; i < 8; i++) begin
        int ic0, dc0;
        logic ge0;
        m_access(0, (i == 0) ? 8'h56 : 8'(8'hB0 + i), 1'b0, 1'b1,
                 (i == 0) ? 8'h11 : 8'(8'h20 + i), 8'h00, 1'b0, ic0, dc0, ge0);
      end
      for (int i = 0; i < 8; i++) begin
        int ic1, dc1;
        logic ge1;
        m_access(1, (i == 0) ? 8'h56 : 8'(8'hB0 + i), 1'b1, 1'b0, 8'h00,
                 (i == 0) ? 8'h11 : 8'(8'h20 + i), 1'b0, ic1, dc1, ge1);
      end
    join
    checks++;
    if (order_q.size() != 16) begin
      failures++;
      $display("FAIL alternation_count got=%0d exp=16", order_q.size());
    end
    for (int i = 0; i < order_q.size(); i++) begin
      checks++;
      if (order_q[i] != (i % 2)) begin
        failures++;
        $display("FAIL alternation idx=%0d got=m%0d exp=m%0d", i, order_q[i], i % 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ic1, dc1, ic2, dc2;
    logic ge1, ge2;
    m_access(1, 8'h9a, 1'b0, 1'b1, 8'h3C, 8'h00, 1'b0, ic1, dc1, ge1);
    checks++;
    if (dbg_state !== ST_TURN || s_read !== 1'b0 || s_write !== 1'b0) begin
      failures++;
      $display("FAIL turn_cycle got=%0d rd=%b wr=%b exp=%0d 0 0", dbg_state, s_read, s_write, ST_TURN);
    end
    m_access(1, 8'h9a, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b0, ic2, dc2, ge2);
    checks++;
    if (dc1 !== ic1 + 1 + WS) begin
      failures++;
      $display("FAIL b2b_first_latency got=%0d exp=%0d", dc1 - ic1, 1 + WS);
    end
    checks++;
    if (dc2 - dc1 !== 3 + WS || ge1 || ge2) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d exp=%0d", dc2 - dc1, 3 + WS);
    end
  endtask

  task automatic test_read_write();
    int ic, dc;
    logic ge;
    m_access(0, 8'hC0, 1'b1, 1'b1, 8'h77, 8'h00, 1'b0, ic, dc, ge);
    checks++;
    if (dc !== ic + 1 + WS || ge !== 1'b0) begin
      failures++;
      $display("FAIL rw_both_latency got=%0d exp=%0d", dc - ic, 1 + WS);
    end
    m_access(0, 8'hC0, 1'b1, 1'b0, 8'h00, 8'h77, 1'b0, ic, dc, ge);
  endtask

  task automatic test_addr_hold();
    int ic, dc;
    logic ge;
    fork
      m_access(0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, ic, dc, ge);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        m0_addr = 8'h9a;
        for (int k = 0; k <= WS; k++) begin
          @(negedge clk);
          checks++;
          if (s_addr !== 8'h00 || s_read !== 1'b1) begin
            failures++;
            $display("FAIL addr_hold k=%0d got=%h exp=00", k, s_addr);
          end
        end
      end
    join
    checks++;
    if (dc !== ic + 1 + WS) begin
      failures++;
      $display("FAIL addr_hold_latency got=%0d exp=%0d", dc - ic, 1 + WS);
    end
  endtask

  task automatic test_timeout();
    int ica, dca, icb, dcb;
    logic gea, geb;
    ram_stall = 1'b1;
    err_ok0 = 1'b1;
    fork
      begin
        m_access(0, 8'h40, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, ica, dca, gea);
        ram_stall = 1'b0;
        for (int k = 0; k <= WS; k++) begin
          @(negedge clk);
          checks++;
          if (dbg_state !== ST_DRAIN || s_read !== 1'b0) begin
            failures++;
            $display("FAIL timeout_drain k=%0d got=%0d/%b exp=%0d/0", k, dbg_state, s_read, ST_DRAIN);
          end
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_IDLE) begin
          failures++;
          $display("FAIL timeout_idle got=%0d exp=%0d", dbg_state, ST_IDLE);
        end
      end
      begin
        repeat (3) @(posedge clk);
        m_access(1, 8'h34, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, icb, dcb, geb);
      end
    join
    err_ok0 = 1'b0;
    checks++;
    if (gea !== 1'b1 || dca !== ica + TO) begin
      failures++;
      $display("FAIL timeout_err got_err=%b at=%0d exp_err=1 at=%0d", gea, dca - ica, TO);
    end
    checks++;
    if (geb !== 1'b0 || dcb !== dca + 3 + 2 * WS) begin
      failures++;
      $display("FAIL timeout_next_m1 got=%0d exp=%0d", dcb - dca, 3 + 2 * WS);
    end
  endtask

  task automatic test_reset_busy();
    int ic, dc;
    logic ge;
    @(posedge clk); #1;
    m0_addr = 8'h34; m0_read = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (s_read !== 1'b1) begin
      failures++;
      $display("FAIL rst_busy_first got=%b exp=1", s_read);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    m0_read = 1'b0;
    @(negedge clk);
    checks++;
    if (s_read !== 1'b1) begin
      failures++;
      $display("FAIL rst_busy_hold got=%b exp=1", s_read);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k <= WS; k++) begin
      @(negedge clk);
      checks++;
      if (dbg_state !== ST_DRAIN || s_read !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
        failures++;
        $display("FAIL rst_busy_drain k=%0d state=%0d s_read=%b m0_ready=%b exp DRAIN 0 0",
                 k, dbg_state, s_read, m0_ready);
      end
    end
    m_access(0, 8'h78, 1'b1, 1'b0, 8'h00, 8'hE7, 1'b0, ic, dc, ge);
    checks++;
    if (dc !== ic + 1 + WS || ge !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy_fresh got=%0d exp=%0d", dc - ic, 1 + WS);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1;
    m0_addr = 8'h00; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 8'h00;
    m1_addr = 8'h00; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 8'h00;
    for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    ram[8'h34] <= 8'hA5;
    ram[8'h78] <= 8'hE7;
    ram[8'h00] <= 8'h5A;

    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_read_write();
    test_addr_hold();
    test_timeout();
    test_reset_busy();

    repeat (4) @(negedge clk);
    checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained got=%0d/%0d exp=0/0", exp0_q.size(), exp1_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
